// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//  Bundles the pipeline-status inputs and the stage-register control outputs
//  exchanged between the hazard controller and the 5-stage datapath.
//  Modports:
//    master : hazard controller. It reads the decode, EX and MEM status and
//             the memory ack. It drives the enables, flushes, mem_req and
//             mem_error.
//    slave  : datapath / memory side, the mirror image of master.
//  Signals:
//    id_opcode, id_rs, id_rt   instruction currently in ID
//    ex_opcode, ex_rd          instruction held in ID/EX
//    branch_taken              branch resolved taken in EX
//    mem_opcode, mem_ack       instruction in EX/MEM, memory completion
//    mem_req                   memory access request
//    *_en / *_flush            stage-register load enables / bubble loads
//    mem_error                 sticky memory-timeout flag
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 3
);
  logic [3:0]       id_opcode;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [3:0]       ex_opcode;
  logic [REG_W-1:0] ex_rd;
  logic             branch_taken;
  logic [3:0]       mem_opcode;
  logic             mem_ack;

  logic             mem_req;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_flush;
  logic             mem_error;

  modport master (
    input  id_opcode, id_rs, id_rt, ex_opcode, ex_rd, branch_taken,
           mem_opcode, mem_ack,
    output mem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, mem_error
  );

  modport slave (
    output id_opcode, id_rs, id_rt, ex_opcode, ex_rd, branch_taken,
           mem_opcode, mem_ack,
    input  mem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, mem_error
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//  Sequences the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers
//  of a 5-stage pipeline. It detects load-use hazards, flushes the two
//  younger instructions on a taken branch, and runs the req/ack handshake
//  for the MEM stage. An optional timeout forces the pipeline forward when
//  memory stops answering.
//
//  Ports:
//    clock   in   rising-edge clock
//    reset   in   asynchronous, active-low reset
//    bus     pipeline_hazard_ctrl_if.master (status in, enables/flushes out)
//    stall_cycles[15:0], flush_count[15:0]   only with PIPE_PERF_CNT_EN
//
//  Build option:
//    PIPE_PERF_CNT_EN  When defined, this adds the saturating stall-cycle and
//                      branch-flush counter outputs.
//
//  Registers: FSM state, wait counter and the sticky mem_error flag. All
//  other outputs are combinational from those registers and the inputs.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int         REG_W       = 3,
  parameter logic [3:0] OP_LOAD     = 4'h2,
  parameter logic [3:0] OP_STORE    = 4'h3,
  parameter int         MEM_TIMEOUT = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.master bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [15:0]            stall_cycles,
  output logic [15:0]            flush_count
`endif
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] TIMEOUT_VAL = 4'(MEM_TIMEOUT);
  localparam bit         TIMEOUT_EN  = (MEM_TIMEOUT != 0);

  state_t     state_reg;
  logic [3:0] wcnt_reg;
  logic       mem_error_reg;

  logic [REG_W-1:0] ex_rd;
  logic             is_mem;
  logic             req_int;
  logic             timeout_hit;
  logic             mem_stall;
  logic             load_use;
  logic             branch_flush;

  assign ex_rd  = bus.ex_rd;
  assign is_mem = (bus.mem_opcode == OP_LOAD) || (bus.mem_opcode == OP_STORE);

  // Ungated request. The request driven to memory is additionally gated by
  // reset, so an abandoned access is dropped as soon as reset goes low.
  assign req_int = ((state_reg == RUN) && is_mem) || (state_reg == MEM_WAIT);

  assign timeout_hit = TIMEOUT_EN && (state_reg == MEM_WAIT) &&
                       (wcnt_reg == TIMEOUT_VAL) && !bus.mem_ack;

  assign mem_stall = req_int && !bus.mem_ack && !timeout_hit;

  // Register 0 is hardwired, so a load that targets it never creates a hazard.
  assign load_use = (bus.ex_opcode == OP_LOAD) && (ex_rd != '0) &&
                    ((ex_rd == bus.id_rs) || (ex_rd == bus.id_rt));

  // A branch seen while MEM is stalled is ignored. EX is frozen, so the
  // same branch is presented again on the cycle the stall releases.
  assign branch_flush = bus.branch_taken && !mem_stall;

  // Stage-register control. Priority: mem stall > branch > load-use > normal.
  always_comb begin
    bus.mem_req      = reset && req_int;
    bus.pc_en        = 1'b1;
    bus.if_id_en     = 1'b1;
    bus.id_ex_en     = 1'b1;
    bus.ex_mem_en    = 1'b1;
    bus.mem_wb_en    = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.mem_wb_flush = 1'b0;
    if (!reset) begin
      bus.pc_en        = 1'b0;
      bus.if_id_en     = 1'b0;
      bus.id_ex_en     = 1'b0;
      bus.ex_mem_en    = 1'b0;
      bus.mem_wb_en    = 1'b0;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      bus.mem_wb_flush = 1'b1;
    end else if (mem_stall) begin
      // Freeze everything up to EX/MEM. WB still loads, but it loads a bubble.
      bus.pc_en        = 1'b0;
      bus.if_id_en     = 1'b0;
      bus.id_ex_en     = 1'b0;
      bus.ex_mem_en    = 1'b0;
      bus.mem_wb_flush = 1'b1;
    end else if (bus.branch_taken) begin
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
    end else if (load_use) begin
      // Hold the consumer in ID for one cycle and insert a bubble into EX.
      bus.pc_en        = 1'b0;
      bus.if_id_en     = 1'b0;
      bus.id_ex_flush  = 1'b1;
    end
  end

  assign bus.mem_error = mem_error_reg;

  // Memory handshake FSM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= RUN;
      wcnt_reg      <= 4'd0;
      mem_error_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (is_mem && !bus.mem_ack) begin
            state_reg <= MEM_WAIT;
            wcnt_reg  <= 4'd1;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ack || timeout_hit) begin
            state_reg <= RUN;
            wcnt_reg  <= 4'd0;
          end else if (wcnt_reg != 4'hF) begin
            // Saturate so a build without a timeout cannot wrap the count.
            wcnt_reg <= wcnt_reg + 4'd1;
          end
        end
        default: begin
          state_reg <= RUN;
          wcnt_reg  <= 4'd0;
        end
      endcase
      if (timeout_hit) begin
        mem_error_reg <= 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic stall_event;
  assign stall_event = mem_stall || (load_use && !bus.branch_taken);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else begin
      if (stall_event && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if (branch_flush && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//  Directed testbench for pipeline_hazard_ctrl. The design outputs are packed
//  into one 9-bit control word:
//    {mem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//     if_id_flush, id_ex_flush, mem_wb_flush}
//  That word is compared against hand-computed constants.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;

  // Expected control words
  localparam logic [8:0] W_RESET   = 9'b0_00000_111;
  localparam logic [8:0] W_NORMAL  = 9'b0_11111_000;
  localparam logic [8:0] W_LDUSE   = 9'b0_00111_010;
  localparam logic [8:0] W_MSTALL  = 9'b1_00001_001;
  localparam logic [8:0] W_MADV    = 9'b1_11111_000;
  localparam logic [8:0] W_BRANCH  = 9'b0_11111_110;
  localparam logic [8:0] W_MBRANCH = 9'b1_11111_110;
  localparam logic [8:0] W_MLDUSE  = 9'b1_00111_010;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  pipeline_hazard_ctrl_if #(.REG_W(3)) bus ();

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  pipeline_hazard_ctrl #(
    .REG_W      (3),
    .OP_LOAD    (OP_LOAD),
    .OP_STORE   (OP_STORE),
    .MEM_TIMEOUT(15)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [8:0] ctrl_word();
    return {bus.mem_req, bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
            bus.mem_wb_en, bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Drive inputs shortly after a rising edge, then check mid-cycle on the
  // falling edge and advance to just past the next rising edge.
  task automatic drive(input logic [3:0] ex_op, input logic [2:0] ex_rd,
                       input logic [2:0] rs, input logic [2:0] rt,
                       input logic br, input logic [3:0] mem_op,
                       input logic ack);
    bus.id_opcode    = 4'h1;
    bus.ex_opcode    = ex_op;
    bus.ex_rd        = ex_rd;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.branch_taken = br;
    bus.mem_opcode   = mem_op;
    bus.mem_ack      = ack;
  endtask

  task automatic cycle_check(input string tag, input logic [8:0] exp);
    @(negedge clock);
    check_eq(tag, 32'(ctrl_word()), 32'(exp));
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 4'h0, 1'b0);

    // Reset held low for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq($sformatf("reset_ctrl%0d", i), 32'(ctrl_word()), 32'(W_RESET));
    end
    check_eq("reset_err", 32'(bus.mem_error), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    cycle_check("release_normal", W_NORMAL);

    // Load-use through rs, one stall cycle, then the bubble clears it
    drive(OP_LOAD, 3'd3, 3'd3, 3'd5, 1'b0, 4'h0, 1'b0);
    cycle_check("lduse_rs", W_LDUSE);
    drive(4'h0, 3'd0, 3'd3, 3'd5, 1'b0, 4'h0, 1'b0);
    cycle_check("lduse_clear", W_NORMAL);
    // Load-use through rt
    drive(OP_LOAD, 3'd6, 3'd1, 3'd6, 1'b0, 4'h0, 1'b0);
    cycle_check("lduse_rt", W_LDUSE);
    // ex_rd = 0 never stalls
    drive(OP_LOAD, 3'd0, 3'd0, 3'd0, 1'b0, 4'h0, 1'b0);
    cycle_check("lduse_r0", W_NORMAL);
    // Non-load producer never stalls
    drive(OP_STORE, 3'd3, 3'd3, 3'd3, 1'b0, 4'h0, 1'b0);
    cycle_check("lduse_store", W_NORMAL);

    // Memory wait: ack low 4 cycles, then high
    for (int i = 0; i < 4; i++) begin
      drive(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, OP_LOAD, 1'b0);
      cycle_check($sformatf("mwait_stall%0d", i), W_MSTALL);
    end
    drive(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, OP_LOAD, 1'b1);
    cycle_check("mwait_ack", W_MADV);
    drive(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 4'h0, 1'b0);
    cycle_check("mwait_back_run", W_NORMAL);

    // Zero-wait store
    drive(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, OP_STORE, 1'b1);
    cycle_check("zwait_store", W_MADV);
    drive(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 4'h0, 1'b0);
    cycle_check("zwait_stays_run", W_NORMAL);

    // Plain branch
    drive(4'h0, 3'd0, 3'd0, 3'd0, 1'b1, 4'h0, 1'b0);
    cycle_check("branch", W_BRANCH);

    // Branch during a memory stall is held off until the ack cycle
    drive(4'h0, 3'd0, 3'd0, 3'd0, 1'b1, OP_LOAD, 1'b0);
    cycle_check("br_mstall0", W_MSTALL);
    cycle_check("br_mstall1", W_MSTALL);
    drive(4'h0, 3'd0, 3'd0, 3'd0, 1'b1, OP_LOAD, 1'b1);
    cycle_check("br_mack", W_MBRANCH);

    // Branch and load-use together: the flush wins
    drive(OP_LOAD, 3'd2, 3'd2, 3'd0, 1'b1, 4'h0, 1'b0);
    cycle_check("br_lduse", W_BRANCH);

    // Load-use on the same cycle as a memory ack: load-use applies
    drive(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, OP_LOAD, 1'b0);
    cycle_check("ldack_stall", W_MSTALL);
    drive(OP_LOAD, 3'd4, 3'd4, 3'd0, 1'b0, OP_LOAD, 1'b1);
    cycle_check("ldack_lduse", W_MLDUSE);
    drive(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 4'h0, 1'b0);
    cycle_check("ldack_after", W_NORMAL);

    // Reset asserted mid MEM_WAIT drops mem_req at once
    drive(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, OP_LOAD, 1'b0);
    cycle_check("rstmid_stall0", W_MSTALL);
    cycle_check("rstmid_stall1", W_MSTALL);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("rstmid_ctrl", 32'(ctrl_word()), 32'(W_RESET));
    @(posedge clock);
    #1 reset = 1'b1;
    drive(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 4'h0, 1'b0);
    cycle_check("rstmid_run", W_NORMAL);

    // Timeout: ack never arrives. 15 stall cycles, then a forced advance.
    for (int i = 0; i < 15; i++) begin
      drive(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, OP_LOAD, 1'b0);
      cycle_check($sformatf("tmo_stall%0d", i), W_MSTALL);
    end
    @(negedge clock);
    check_eq("tmo_advance", 32'(ctrl_word()), 32'(W_MADV));
    check_eq("tmo_err_before", 32'(bus.mem_error), 32'd0);
    @(posedge clock);
    #1;
    drive(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 4'h0, 1'b0);
    @(negedge clock);
    check_eq("tmo_after_ctrl", 32'(ctrl_word()), 32'(W_NORMAL));
    check_eq("tmo_err_set", 32'(bus.mem_error), 32'd1);
`ifdef PIPE_PERF_CNT_EN
    check_eq("tmo_stall_cycles", 32'(stall_cycles), 32'd15);
`endif
    repeat (3) @(posedge clock);
    #1;
    check_eq("tmo_err_sticky", 32'(bus.mem_error), 32'd1);

    // Only reset clears mem_error
    reset = 1'b0;
    @(negedge clock);
    check_eq("err_cleared", 32'(bus.mem_error), 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    cycle_check("final_normal", W_NORMAL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
